// File: rtl/uart_rx_buffered_if.sv
// Bus-side interface of the buffered UART receiver: FIFO read port and status flags.
// parity_error exists only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
interface uart_rx_buffered_if;
    logic       read_en;
    logic       clear_flags;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       frame_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;

    modport master (output read_en, clear_flags,
                    input  data_out, empty, full, overflow, frame_error, parity_error);
    modport slave  (input  read_en, clear_flags,
                    output data_out, empty, full, overflow, frame_error, parity_error);
`else
    modport master (output read_en, clear_flags,
                    input  data_out, empty, full, overflow, frame_error);
    modport slave  (input  read_en, clear_flags,
                    output data_out, empty, full, overflow, frame_error);
`endif
endinterface

// File: rtl/uart_rx_buffered.sv
// UART receiver (8N1, LSB first) feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_error pulse.
`timescale 1ns/1ps
module uart_rx_buffered #(
    parameter int CLOCK_FREQ  = 25000000,
    parameter int BIT_RATE    = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    uart_rx_buffered_if.slave  bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE;
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PTR_W:0]   DEPTH    = (PTR_W+1)'(BUFFER_SIZE);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t           state;
    logic             rx_p0, rx_p1;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             push_req;
    logic             frame_error_q;
    logic             overflow_q;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic [7:0]       mem [BUFFER_SIZE];
    logic             rx_s, data_sample, do_push, do_pop;
`ifdef UART_RX_PARITY_EN
    logic             parity_bad, parity_error_q;
`endif

    // stage p0/p1: metastability chain, preset to the idle level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign rx_s        = rx_p1;
    assign data_sample = (state == DATA) && (baud_cnt == BIT_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            push_req      <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad     <= 1'b0;
            parity_error_q <= 1'b0;
`endif
        end else begin
            push_req      <= 1'b0;
            frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q <= 1'b0;
`endif
            case (state)
                IDLE: if (!rx_s) begin
                    state    <= START;
                    baud_cnt <= '0;
                end
                START: if (baud_cnt == HALF_END) begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    state    <= rx_s ? IDLE : DATA;
                end else baud_cnt <= baud_cnt + 1'b1;
                DATA: if (baud_cnt == BIT_END) begin
                    baud_cnt <= '0;
                    bit_idx  <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx == 3'd7) state <= PARITY;
`else
                    if (bit_idx == 3'd7) state <= STOP;
`endif
                end else baud_cnt <= baud_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                // even parity: data bits plus parity bit must XOR to zero
                PARITY: if (baud_cnt == BIT_END) begin
                    baud_cnt       <= '0;
                    parity_bad     <= ^{shift, rx_s};
                    parity_error_q <= ^{shift, rx_s};
                    state          <= STOP;
                end else baud_cnt <= baud_cnt + 1'b1;
`endif
                STOP: if (baud_cnt == BIT_END) begin
                    baud_cnt <= '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        push_req <= !parity_bad;
`else
                        push_req <= 1'b1;
`endif
                        state    <= IDLE;
                    end else begin
                        frame_error_q <= 1'b1;
                        state         <= BREAK;
                    end
                end else baud_cnt <= baud_cnt + 1'b1;
                // a line held low must return high before another start bit counts
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (data_sample) shift <= {rx_s, shift[7:1]};
    end

    // stage p2: FIFO update, one cycle after the stop-bit sample
    assign do_pop  = bus.read_en && (count != '0);
    assign do_push = push_req && ((count != DEPTH) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
            if (push_req && !do_push)  overflow_q <= 1'b1;
            else if (bus.clear_flags)  overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    assign bus.data_out    = (count == '0) ? 8'h00 : mem[rd_ptr];
    assign bus.empty       = (count == '0);
    assign bus.full        = (count == DEPTH);
    assign bus.overflow    = overflow_q;
    assign bus.frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = parity_error_q;
`endif
endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- UART receiver with a receive FIFO. It is the receive end of the SOC's UART serial link, and the FPGA-side counterpart of the SOC's transmit path.
- Samples the asynchronous rx pin, deframes 8N1 characters (LSB first), and queues them in a FIFO for a bus-side reader.
- Sits between the top-level rx pin and the SOC peripheral bus / UART register block.

Parameters:
- CLOCK_FREQ, 25000000, system clock frequency in Hz.
- BIT_RATE, 115200, serial bit rate in baud.
- BUFFER_SIZE, 16, FIFO depth in bytes; must be a power of 2 and at least 2.
- Derived, not a port parameter: CLKS_PER_BIT = CLOCK_FREQ / BIT_RATE, integer truncation (217 at defaults).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial input; asynchronous to clk; idles high.
- read_en  input  1  pops the FIFO head when empty=0.
- data_out  output  8  FIFO head byte; first-word-fall-through.
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds BUFFER_SIZE bytes.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.
- frame_error  output  1  one-cycle pulse on a bad stop bit.
- clear_flags  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rx synchroniser=1, counters=0, FIFO pointers=0.
  - Outputs: empty=1, full=0, overflow=0, frame_error=0, data_out=8'h00.
  - Reset in mid-frame discards the partial byte. FIFO contents are lost.
- rx synchroniser: 2-FF chain, preset to 1 on reset. All FSM decisions use the synchronised value rx_s.
- FSM:
  - IDLE: on rx_s=0 → START, baud_cnt=0.
  - START:
    - Count to CLKS_PER_BIT/2 - 1, then sample rx_s.
    - rx_s=0 → DATA, bit_idx=0, baud_cnt=0.
    - rx_s=1 → IDLE (glitch rejected, nothing pushed).
  - DATA:
    - Sample rx_s each time baud_cnt reaches CLKS_PER_BIT-1; the counter then wraps to 0.
    - Shift the sample in LSB first.
    - After bit_idx=7 → STOP.
  - STOP:
    - Sample at CLKS_PER_BIT-1.
    - rx_s=1 → push byte, → IDLE.
    - rx_s=0 → frame_error=1 for one cycle, byte discarded, → BREAK.
  - BREAK: wait for rx_s=1, then → IDLE. This prevents a held-low line from retriggering.
- Push/pop rules:
  - Push occurs on the cycle after the stop sample.
  - Push while full and read_en=0: byte dropped, overflow←1.
  - Push and read_en in the same cycle while full: both succeed, count unchanged, no overflow.
  - read_en while empty: ignored; pointers and count unchanged.
  - Simultaneous push and pop while empty: push only.
- Read timing:
  - data_out reflects the new head on the cycle after a pop.
  - With a single entry, empty=1 on the cycle after the pop.
- Pointers: log2(BUFFER_SIZE) bits, wrap naturally. An occupancy count of log2(BUFFER_SIZE)+1 bits drives full and empty.
- overflow: cleared only by reset or clear_flags=1. If a set and a clear occur in the same cycle, the set wins.
- Latency: push occurs 2 (sync) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT + 1 cycles after the falling edge at the pin. Tolerance ±2 cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state follows DATA and samples one extra bit.
  - If the XOR of the 8 data bits and the parity bit is 1: byte discarded, parity_error output (1 bit, one-cycle pulse), → STOP still checked.
  - Latency increases by CLKS_PER_BIT.
- Undefined:
  - No PARITY state; the frame is 8N1.
  - The parity_error port does not exist.

Test Plan:
- Defaults (217 clk/bit): send 8'hA5, 8N1 → empty falls within the latency window; data_out=8'hA5; read_en pulse → empty=1 next cycle.
- 0.5-bit (100-cycle) low glitch on rx → nothing pushed, FSM back in IDLE, no frame_error.
- Send 8'h3C with stop bit=0 → frame_error pulses once, FIFO stays empty. Hold rx low 3 bit times → no spurious push. Release → next byte 8'h55 received correctly.
- Send 17 bytes 8'h00..8'h10 without reading → full=1 after 16, overflow=1 after the 17th. Reading 16 times yields 8'h00..8'h0F in order. clear_flags → overflow=0.
- FIFO full, push coincident with read_en → overflow stays 0, count stays 16, order preserved.
- Assert reset mid-DATA of 8'hFF → all outputs at reset values. The next full frame 8'h81 is received correctly.
- (UART_RX_PARITY_EN) send 8'h07 with parity=0 → parity_error pulse, no push. Send 8'h07 with parity=1 → pushed.
